conv_channel_scheduler: RTL

Sequences one shared spatial convolution datapath across every (kernel, channel) pair of a layer. For each input window position it issues kernel-memory reads and drives the channel select and accumulator controls. It emits one completed per-kernel result into the pooling stage, then releases the window to the input window buffers. It sits between the per-channel input window buffers and kernel memory on one side, and the convolution kernel, channel accumulator and pool stage on the other.

---
 rtl/conv_channel_scheduler_if.sv | 42 ++++
 rtl/conv_channel_scheduler.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/conv_channel_scheduler_if.sv
// Bundle of the handshake, kernel-memory and accumulator-control signals
// around the convolution channel scheduler. The scheduler uses "master";
// the surrounding datapath (or a testbench) uses "slave".
interface conv_channel_scheduler_if #(
  parameter int N_CHANNELS = 1,
  parameter int N_KERNELS  = 32,
  parameter int N_WINDOWS  = 676,
  parameter int ADDR_WIDTH = 16
);
  localparam int CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int K_W  = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1;
  localparam int WC_W = $clog2(N_WINDOWS + 1);

  logic                  enable_i;
  logic [N_CHANNELS-1:0] window_valid_i;
  logic [N_CHANNELS-1:0] window_consume_o;
  logic                  kmem_rd_o;
  logic [ADDR_WIDTH-1:0] kmem_addr_o;
  logic [CH_W-1:0]       channel_sel_o;
  logic                  acc_en_o;
  logic                  acc_clear_o;
  logic                  result_valid_o;
  logic [K_W-1:0]        result_kernel_o;
  logic                  result_ready_i;
  logic [WC_W-1:0]       window_count_o;
  logic                  frame_done_o;
  logic                  busy_o;

  modport master (
    input  enable_i, window_valid_i, result_ready_i,
    output window_consume_o, kmem_rd_o, kmem_addr_o, channel_sel_o,
           acc_en_o, acc_clear_o, result_valid_o, result_kernel_o,
           window_count_o, frame_done_o, busy_o
  );

  modport slave (
    output enable_i, window_valid_i, result_ready_i,
    input  window_consume_o, kmem_rd_o, kmem_addr_o, channel_sel_o,
           acc_en_o, acc_clear_o, result_valid_o, result_kernel_o,
           window_count_o, frame_done_o, busy_o
  );
endinterface

// File: rtl/conv_channel_scheduler.sv
// Time-multiplexes one convolution datapath over every (kernel, channel)
// pair of a window: issues kernel-memory reads, steers the channel mux and
// accumulator one cycle later, hands each finished kernel sum to the pool
// stage and finally releases the window buffers. All outputs are flops.
module conv_channel_scheduler #(
  parameter int N_CHANNELS = 1,
  parameter int N_KERNELS  = 32,
  parameter int N_WINDOWS  = 676,
  parameter int ADDR_WIDTH = 16
) (
  input  logic clock_i,
  input  logic reset_i,
  conv_channel_scheduler_if.master bus
);
  localparam int CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int K_W  = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1;
  localparam int WC_W = $clog2(N_WINDOWS + 1);

  localparam logic [CH_W-1:0] C_LAST  = CH_W'(N_CHANNELS - 1);
  localparam logic [K_W-1:0]  K_LAST  = K_W'(N_KERNELS - 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(N_WINDOWS - 1);

  typedef enum logic [2:0] {
    WAIT_WIN,
    ISSUE,
    DRAIN,
    EMIT,
    CONSUME
  } state_t;

  state_t                state, state_nx;
  logic [K_W-1:0]        k, k_nx;
  logic [CH_W-1:0]       c, c_nx;
  logic [WC_W-1:0]       wcount, wcount_nx;
  logic                  frame_wrap;
  logic [ADDR_WIDTH-1:0] addr_nx;

  logic                  rd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CH_W-1:0]       sel_q;
  logic                  acc_en_q;
  logic                  acc_clear_q;
  logic                  res_valid_q;
  logic [K_W-1:0]        res_kernel_q;
  logic [N_CHANNELS-1:0] consume_q;
  logic                  frame_done_q;
  logic                  busy_q;

  assign addr_nx = ADDR_WIDTH'(k_nx) * ADDR_WIDTH'(N_CHANNELS) + ADDR_WIDTH'(c_nx);

  // Next-state logic; the window counter advances on the edge entering CONSUME
  always_comb begin
    state_nx   = state;
    k_nx       = k;
    c_nx       = c;
    wcount_nx  = wcount;
    frame_wrap = 1'b0;
    case (state)
      WAIT_WIN: begin
        if (bus.enable_i && (&bus.window_valid_i)) begin
          state_nx = ISSUE;
          k_nx     = '0;
          c_nx     = '0;
        end
      end
      ISSUE: begin
        if (c != C_LAST) c_nx = c + CH_W'(1);
        else             state_nx = DRAIN;
      end
      DRAIN: state_nx = EMIT;
      EMIT: begin
        if (bus.result_ready_i) begin
          if (k != K_LAST) begin
            k_nx     = k + K_W'(1);
            c_nx     = '0;
            state_nx = ISSUE;
          end else begin
            state_nx = CONSUME;
            if (wcount == WC_LAST) begin
              wcount_nx  = '0;
              frame_wrap = 1'b1;
            end else begin
              wcount_nx = wcount + WC_W'(1);
            end
          end
        end
      end
      CONSUME: state_nx = WAIT_WIN;
      default: state_nx = WAIT_WIN;
    endcase
  end

  // State and loop-index registers
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state  <= WAIT_WIN;
      k      <= '0;
      c      <= '0;
      wcount <= '0;
    end else begin
      state  <= state_nx;
      k      <= k_nx;
      c      <= c_nx;
      wcount <= wcount_nx;
    end
  end

  // Registered outputs: reads follow the next state, accumulator controls lag the read by one cycle
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_q         <= 1'b0;
      addr_q       <= '0;
      sel_q        <= '0;
      acc_en_q     <= 1'b0;
      acc_clear_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_kernel_q <= '0;
      consume_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rd_q         <= (state_nx == ISSUE);
      addr_q       <= (state_nx == ISSUE) ? addr_nx : '0;
      acc_en_q     <= (state == ISSUE);
      sel_q        <= (state == ISSUE) ? c : '0;
      acc_clear_q  <= (state == ISSUE) && (c == '0);
      res_valid_q  <= (state_nx == EMIT);
      res_kernel_q <= (state_nx == EMIT) ? k_nx : '0;
      consume_q    <= {N_CHANNELS{state_nx == CONSUME}};
      frame_done_q <= frame_wrap;
      busy_q       <= (state_nx != WAIT_WIN);
    end
  end

  assign bus.kmem_rd_o        = rd_q;
  assign bus.kmem_addr_o      = addr_q;
  assign bus.channel_sel_o    = sel_q;
  assign bus.acc_en_o         = acc_en_q;
  assign bus.acc_clear_o      = acc_clear_q;
  assign bus.result_valid_o   = res_valid_q;
  assign bus.result_kernel_o  = res_kernel_q;
  assign bus.window_consume_o = consume_q;
  assign bus.window_count_o   = wcount;
  assign bus.frame_done_o     = frame_done_q;
  assign bus.busy_o           = busy_q;
endmodule
